idx_list_serializer: RTL and testbench

//  Consumer of the compacted index lists built by the index-merge tree: takes a list of 1..4

---
 rtl/idx_list_serializer_pkg.sv | 23 ++
 rtl/idx_list_serializer.sv | 118 +++++++++++
 tb/tb_idx_list_serializer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/idx_list_serializer_pkg.sv
// Shared definitions for the index-merge tree and its list serializer.
// Count widths live here so producer and consumer agree on list sizing.
package idx_list_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    localparam int unsigned MAX_LIST   = 4;
    localparam int unsigned LIST_CNT_W = 3;

    localparam logic [LIST_CNT_W-1:0] MAX_CNT = LIST_CNT_W'(MAX_LIST);

    typedef enum logic {
        StIdle  = ST_IDLE,
        StDrain = ST_DRAIN
    } state_e;

    // Oversized counts are truncated to a full list.
    function automatic logic [LIST_CNT_W-1:0] clamp_count(input logic [LIST_CNT_W-1:0] num);
        return (num > MAX_CNT) ? MAX_CNT : num;
    endfunction

endpackage

// File: rtl/idx_list_serializer.sv
// Serializes a compacted list of up to four indices into one index per beat.
// One list is buffered so that a new list can load on the final beat of the current one.
module idx_list_serializer
    import idx_list_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_idx1,
    input  logic [WIDTH-1:0] i_idx2,
    input  logic [WIDTH-1:0] i_idx3,
    input  logic [WIDTH-1:0] i_idx4,
    input  logic [2:0]       i_num,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_idx,
    output logic [1:0]       o_pos,
    output logic             o_last,
    output logic             o_empty_pulse,
    output logic             o_err
);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        slot_q [MAX_LIST];
    logic [WIDTH-1:0]        slot_d [MAX_LIST];
    logic [WIDTH-1:0]        in_slot [MAX_LIST];
    logic [LIST_CNT_W-1:0]   num_q, num_d;
    logic [1:0]              ptr_q, ptr_d;
    logic                    empty_q, empty_d;
    logic                    err_q, err_d;

    logic                    drain;
    logic                    last_beat;
    logic                    accept;
    logic                    take;

    assign in_slot[0] = i_idx1;
    assign in_slot[1] = i_idx2;
    assign in_slot[2] = i_idx3;
    assign in_slot[3] = i_idx4;

    assign drain     = (state_q == StDrain);
    assign last_beat = drain && ({1'b0, ptr_q} == (num_q - 3'd1));
    assign take      = drain && i_out_ready;

    // Ready looks only at held state and downstream ready, never at i_in_valid.
    assign o_in_ready = (state_q == StIdle) || (last_beat && i_out_ready);
    assign accept     = i_in_valid && o_in_ready;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        ptr_d   = ptr_q;
        empty_d = 1'b0;
        err_d   = err_q;
        for (int unsigned i = 0; i < MAX_LIST; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (take) begin
            if (last_beat) begin
                state_d = StIdle;
            end else begin
                ptr_d = ptr_q + 2'd1;
            end
        end

        if (accept) begin
            if (i_num == 3'd0) begin
                empty_d = 1'b1;
                state_d = StIdle;
            end else begin
                for (int unsigned i = 0; i < MAX_LIST; i++) begin
                    slot_d[i] = in_slot[i];
                end
                num_d   = clamp_count(i_num);
                ptr_d   = 2'd0;
                state_d = StDrain;
                if (i_num > MAX_CNT) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            ptr_q   <= '0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < MAX_LIST; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            ptr_q   <= ptr_d;
            empty_q <= empty_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < MAX_LIST; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign o_out_valid   = drain;
    assign o_idx         = drain ? slot_q[ptr_q] : '0;
    assign o_pos         = drain ? ptr_q : 2'd0;
    assign o_last        = last_beat;
    assign o_empty_pulse = empty_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_idx_list_serializer.sv
// Self-checking bench: per-cycle comparison against a queue-based model of the expected beat
// stream, plus literal expectations from hand-worked directed scenarios.
module tb_idx_list_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] slot_in [4];
    logic [2:0]   num;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] idx;
    logic [1:0]   pos;
    logic         last;
    logic         empty_pulse;
    logic         err;

    always #5 clk = ~clk;

    idx_list_serializer #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_idx1        (slot_in[0]),
        .i_idx2        (slot_in[1]),
        .i_idx3        (slot_in[2]),
        .i_idx4        (slot_in[3]),
        .i_num         (num),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_idx         (idx),
        .o_pos         (pos),
        .o_last        (last),
        .o_empty_pulse (empty_pulse),
        .o_err         (err)
    );

    typedef struct {
        int idx;
        int pos;
        int last;
    } beat_t;

    int     n_chk  = 0;
    int     n_pass = 0;
    beat_t  exp_q[$];
    beat_t  log_q[$];
    int     log_cyc[$];
    bit     exp_empty = 0;
    bit     exp_err   = 0;
    int     cyc       = 0;
    int     acc_cyc   = 0;
    int     acc_n     = 0;
    int     empty_n   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_list(input bit v, input int n, input int a, input int b, input int c,
                            input int d);
        in_valid   = v;
        num        = 3'(n);
        slot_in[0] = W'(a);
        slot_in[1] = W'(b);
        slot_in[2] = W'(c);
        slot_in[3] = W'(d);
    endtask

    // One clock: compare outputs to the model, advance the model, cross the edge.
    task automatic tick();
        bit model_ready;
        bit take;
        bit acc;
        int n;
        #1;
        model_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        chk("out_valid", out_valid, int'(exp_q.size() != 0));
        chk("in_ready", in_ready, int'(model_ready));
        if (exp_q.size() != 0) begin
            chk("idx", idx, exp_q[0].idx);
            chk("pos", pos, exp_q[0].pos);
            chk("last", last, exp_q[0].last);
        end
        chk("empty_pulse", empty_pulse, int'(exp_empty));
        chk("err", err, int'(exp_err));
        if (!rst_n) begin
            exp_q.delete();
            exp_empty = 0;
            exp_err   = 0;
        end else begin
            take = (exp_q.size() != 0) && out_ready;
            acc  = in_valid && model_ready;
            if (take) begin
                log_q.push_back(exp_q[0]);
                log_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            exp_empty = 0;
            if (acc) begin
                acc_cyc = cyc;
                acc_n++;
                if (num == 3'd0) begin
                    exp_empty = 1;
                    empty_n++;
                end else begin
                    n = (num > 3'd4) ? 4 : int'(num);
                    for (int k = 0; k < n; k++) begin
                        exp_q.push_back('{idx: int'(slot_in[k]), pos: k, last: int'(k == n - 1)});
                    end
                    if (num > 3'd4) exp_err = 1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic chk_seq(input string name, input int base, input int n, input int v[4]);
        chk({name, "_count"}, log_q.size() - base, n);
        for (int i = 0; i < n && base + i < log_q.size(); i++) begin
            chk({name, "_idx"}, log_q[base + i].idx, v[i]);
            chk({name, "_pos"}, log_q[base + i].pos, i % 4);
        end
    endtask

    initial begin
        int base;
        int guard;
        int seq[4];
        int rpat[8];

        rst_n = 1'b0;
        out_ready = 1'b1;
        set_list(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idx", idx, 0);
        chk("rst_pos", pos, 0);
        chk("rst_last", last, 0);
        chk("rst_empty", empty_pulse, 0);
        chk("rst_err", err, 0);

        // Single list, continuous ready.
        base = log_q.size();
        set_list(1, 3, 5, 9, 2, 15);
        tick();
        set_list(0, 0, 7, 7, 7, 7);
        drain(10);
        seq = '{5, 9, 2, 0};
        chk_seq("single", base, 3, seq);
        if (log_q.size() - base == 3) begin
            chk("single_latency", log_cyc[base] - acc_cyc, 1);
            chk("single_contig", log_cyc[base + 2] - log_cyc[base], 2);
            chk("single_last0", log_q[base].last, 0);
            chk("single_last2", log_q[base + 2].last, 1);
        end

        // Back-to-back: B presented while A drains, loads on A's final beat.
        base = log_q.size();
        set_list(1, 2, 1, 3, 14, 14);
        tick();
        set_list(1, 4, 8, 9, 10, 11);
        guard = acc_n;
        for (int i = 0; i < 10 && acc_n == guard; i++) tick();
        chk("b2b_accept", acc_n - guard, 1);
        chk("b2b_accept_cycle", acc_cyc, log_cyc[log_cyc.size() - 1]);
        drain(10);
        chk("b2b_count", log_q.size() - base, 6);
        if (log_q.size() - base == 6) begin
            chk("b2b_contig", log_cyc[base + 5] - log_cyc[base], 5);
            chk("b2b_a1", log_q[base + 1].idx, 3);
            chk("b2b_b0", log_q[base + 2].idx, 8);
            chk("b2b_b3", log_q[base + 5].idx, 11);
        end

        // Backpressure with ready pattern 1,0,0,1,...
        base = log_q.size();
        rpat = '{1, 0, 0, 1, 0, 1, 0, 1};
        out_ready = 1'b1;
        set_list(1, 4, 4, 5, 6, 7);
        tick();
        set_list(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            out_ready = rpat[i][0];
            tick();
        end
        drain(10);
        seq = '{4, 5, 6, 7};
        chk_seq("bp", base, 4, seq);

        // num==0 then num==6.
        base = log_q.size();
        guard = empty_n;
        set_list(1, 0, 9, 9, 9, 9);
        tick();
        set_list(0, 0, 0, 0, 0, 0);
        #1;
        chk("empty_pulse_lit", empty_pulse, 1);
        chk("empty_no_valid", out_valid, 0);
        tick();
        chk("empty_pulse_gone", empty_pulse, 0);
        chk("empty_count", empty_n - guard, 1);
        chk("empty_no_beats", log_q.size() - base, 0);
        set_list(1, 6, 1, 2, 3, 4);
        tick();
        set_list(0, 0, 0, 0, 0, 0);
        drain(10);
        seq = '{1, 2, 3, 4};
        chk_seq("over", base, 4, seq);
        repeat (3) tick();
        chk("err_sticky", err, 1);

        // Reset mid-list after two beats.
        set_list(1, 4, 3, 6, 9, 12);
        out_ready = 1'b1;
        tick();
        set_list(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_idx", idx, 0);
        chk("mrst_pos", pos, 0);
        chk("mrst_last", last, 0);
        chk("mrst_err", err, 0);
        base = log_q.size();
        set_list(1, 1, 12, 5, 5, 5);
        tick();
        set_list(0, 0, 0, 0, 0, 0);
        drain(10);
        seq = '{12, 0, 0, 0};
        chk_seq("mrst_new", base, 1, seq);
        if (log_q.size() - base == 1) chk("mrst_new_last", log_q[base].last, 1);

        // Random lists and random downstream ready.
        for (int i = 0; i < 400; i++) begin
            set_list($urandom_range(0, 1) == 1, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7)
                     : $urandom_range(1, 4), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
